// File: rtl/ler_botao_if.sv
// Request/response bundle between the game controller and the button reader.
// The master drives enable and the raw buttons; the slave (ler_botao) answers.
interface ler_botao_if;
   logic       enable;
   logic [3:0] botoes;
   logic [1:0] botao;
   logic       flag;
   logic       timeout;

   modport master (
      output enable,
      output botoes,
      input  botao,
      input  flag,
      input  timeout
   );

   modport slave (
      input  enable,
      input  botoes,
      output botao,
      output flag,
      output timeout
   );
endinterface

// File: rtl/ler_botao.sv
// Captures a single debounced press-and-release of one of four buttons.
// Reports the index with flag, or flag+timeout if no press completes in time.
module ler_botao #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
   input  logic       clk,
   input  logic       rst_n,
   ler_botao_if.slave bus
);
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_PRESS,
      DEBOUNCE,
      WAIT_RELEASE,
      DONE,
      TIMEOUT
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       sync1, sb;
   logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
   logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
   logic [1:0]       cand, cand_nxt;
   logic [1:0]       botao_q, botao_nxt;
   logic             flag_q, flag_nxt;
   logic             timeout_q, timeout_nxt;
   logic             sb_onehot_c;
   logic [1:0]       sb_idx_c;
   logic [3:0]       cand_mask_c;

   function automatic logic [1:0] enc(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      case (v)
         4'b0010: r = 2'd1;
         4'b0100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   assign sb_onehot_c = (sb != 4'd0) && ((sb & (sb - 4'd1)) == 4'd0);
   assign sb_idx_c    = enc(sb);
   assign cand_mask_c = 4'b0001 << cand;

   assign bus.botao   = botao_q;
   assign bus.flag    = flag_q;
   assign bus.timeout = timeout_q;

   // Two-flop synchronizer for the asynchronous buttons
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 4'd0;
         sb    <= 4'd0;
      end else begin
         sync1 <= bus.botoes;
         sb    <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         deb_cnt   <= '0;
         to_cnt    <= '0;
         cand      <= 2'd0;
         botao_q   <= 2'd0;
         flag_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         deb_cnt   <= deb_cnt_nxt;
         to_cnt    <= to_cnt_nxt;
         cand      <= cand_nxt;
         botao_q   <= botao_nxt;
         flag_q    <= flag_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   // Next state; to_cnt runs continuously across ARM/WAIT_PRESS/DEBOUNCE
   always_comb begin
      state_nxt   = state;
      deb_cnt_nxt = deb_cnt;
      to_cnt_nxt  = to_cnt;
      cand_nxt    = cand;
      botao_nxt   = botao_q;
      flag_nxt    = flag_q;
      timeout_nxt = timeout_q;

      if (state != IDLE && !bus.enable) begin
         state_nxt   = IDLE;
         deb_cnt_nxt = '0;
         to_cnt_nxt  = '0;
         flag_nxt    = 1'b0;
         timeout_nxt = 1'b0;
      end else if ((state == ARM || state == WAIT_PRESS || state == DEBOUNCE)
                   && to_cnt == TO_LIM) begin
         state_nxt   = TIMEOUT;
         deb_cnt_nxt = '0;
         to_cnt_nxt  = '0;
         botao_nxt   = 2'd0;
         flag_nxt    = 1'b1;
         timeout_nxt = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               deb_cnt_nxt = '0;
               to_cnt_nxt  = '0;
               if (bus.enable) begin
                  state_nxt = ARM;
               end
            end
            ARM: begin
               to_cnt_nxt = to_cnt + TO_W'(1);
               if (sb == 4'd0) begin
                  state_nxt = WAIT_PRESS;
               end
            end
            WAIT_PRESS: begin
               to_cnt_nxt = to_cnt + TO_W'(1);
               if (sb_onehot_c) begin
                  state_nxt   = DEBOUNCE;
                  cand_nxt    = sb_idx_c;
                  deb_cnt_nxt = '0;
               end
            end
            DEBOUNCE: begin
               to_cnt_nxt = to_cnt + TO_W'(1);
               if (sb == cand_mask_c) begin
                  if (deb_cnt == DEB_LIM) begin
                     state_nxt   = WAIT_RELEASE;
                     deb_cnt_nxt = '0;
                  end else begin
                     deb_cnt_nxt = deb_cnt + DEB_W'(1);
                  end
               end else begin
                  state_nxt   = WAIT_PRESS;
                  deb_cnt_nxt = '0;
               end
            end
            WAIT_RELEASE: begin
               to_cnt_nxt = '0;
               if (sb == 4'd0) begin
                  if (deb_cnt == DEB_LIM) begin
                     state_nxt   = DONE;
                     deb_cnt_nxt = '0;
                     botao_nxt   = cand;
                     flag_nxt    = 1'b1;
                  end else begin
                     deb_cnt_nxt = deb_cnt + DEB_W'(1);
                  end
               end else begin
                  deb_cnt_nxt = '0;
               end
            end
            DONE, TIMEOUT: begin
               deb_cnt_nxt = '0;
               to_cnt_nxt  = '0;
            end
            default: begin
               state_nxt   = IDLE;
               deb_cnt_nxt = '0;
               to_cnt_nxt  = '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ler_botao.sv
// Randomized bench for ler_botao: a sample-stream reference model predicts each
// capture, a scoreboard queue holds the prediction, a monitor checks the outputs.
module tb_ler_botao;
   localparam int DEB_C = 4;
   localparam int TO_C  = 40;

   typedef struct {
      int         edge_n;
      bit         to;
      logic [1:0] b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] gq[$];
   exp_t       exp_q[$];
   exp_t       cur;
   logic [1:0] botao_m;
   bit         fq;

   ler_botao_if bif();

   ler_botao #(
      .DEBOUNCE_CYCLES(DEB_C),
      .TIMEOUT_CYCLES (TO_C)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (edge %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic add(input logic [3:0] v, input int n);
      for (int i = 0; i < n; i++) gq.push_back(v);
   endtask

   function automatic logic [3:0] gv(input int j);
      return (j < gq.size()) ? gq[j] : 4'd0;
   endfunction

   // Synchronized value the block decides on at the k-th edge after ARM entry
   function automatic logic [3:0] sbv(input int k, input logic [3:0] pre);
      if (k < 2) return pre;
      return gv(k - 2);
   endfunction

   function automatic logic [1:0] idx(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int n = 0; n < 4; n++) if (v[n]) r = 2'(n);
      return r;
   endfunction

   // Scan the sample stream: arm on an all-clear sample, accept D+1 equal one-hot
   // samples before the deadline, then finish after D consecutive clear samples.
   function automatic void predict(input logic [3:0] pre, output int fe,
                                   output bit to, output logic [1:0] b);
      int k, i, a, j, z;
      logic [3:0] v;
      to = 1'b1;
      b  = 2'd0;
      fe = TO_C;
      k  = 1;
      while (k < TO_C && sbv(k, pre) != 4'd0) k++;
      if (k >= TO_C) return;
      i = k + 1;
      a = -1;
      while (i < TO_C && a < 0) begin
         v = sbv(i, pre);
         if ($countones(v) == 1) begin
            j = 1;
            while (j <= DEB_C && i + j < TO_C && sbv(i + j, pre) == v) j++;
            if (j > DEB_C) a = i + DEB_C;
            else if (i + j >= TO_C) i = TO_C;
            else i = i + j + 1;
         end else begin
            i++;
         end
      end
      if (a < 0) return;
      b  = idx(sbv(a, pre));
      to = 1'b0;
      z  = 0;
      for (int m = a + 1; m < a + 10000; m++) begin
         if (sbv(m, pre) == 4'd0) z++;
         else z = 0;
         if (z == DEB_C) begin
            fe = m;
            break;
         end
      end
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // abort_m: 0 none, -1 random, >0 drop enable after that drive index
   task automatic run_txn(input int abort_m, input int rst_j);
      int fe, n0, last, m;
      bit to;
      logic [1:0] b;
      logic [3:0] pre;
      exp_t e;
      pre = bif.botoes;
      predict(pre, fe, to, b);
      n0 = cyc;
      m  = (abort_m < 0) ? $urandom_range(1, fe - 1) : abort_m;
      if (m == 0 && rst_j == 0) begin
         e.edge_n = n0 + 1 + fe;
         e.to     = to;
         e.b      = b;
         exp_q.push_back(e);
      end
      bif.enable = 1'b1;
      bif.botoes = gv(0);
      last = (m > 0) ? m : ((rst_j > 0) ? rst_j : fe + 3);
      for (int j = 1; j <= last; j++) begin
         @(posedge clk);
         #1;
         bif.botoes = gv(j);
      end
      if (rst_j > 0) begin
         rst_n      = 1'b0;
         bif.enable = 1'b0;
         bif.botoes = 4'd0;
         botao_m    = 2'd0;
         #1;
         chk("rst_async_flag", int'(bif.flag), 0);
         chk("rst_async_timeout", int'(bif.timeout), 0);
         chk("rst_async_botao", int'(bif.botao), int'(botao_m));
         @(negedge clk);
         rst_n = 1'b1;
         idle(1);
         return;
      end
      bif.enable = 1'b0;
      if (m == 0) begin
         chk("flag_seen", exp_q.size(), 0);
         exp_q.delete();
         botao_m = b;
      end
      idle(1);
      chk("drop_flag", int'(bif.flag), 0);
      chk("drop_timeout", int'(bif.timeout), 0);
      chk("drop_botao_kept", int'(bif.botao), int'(botao_m));
   endtask

   task automatic rand_gq();
      int len, r;
      logic [3:0] v;
      gq.delete();
      while (gq.size() < TO_C + 10) begin
         r = $urandom_range(0, 99);
         if (r < 35) v = 4'd0;
         else if (r < 85) v = 4'(1 << $urandom_range(0, 3));
         else v = 4'(3 << $urandom_range(0, 2));
         len = $urandom_range(1, 2 * DEB_C + 2);
         add(v, len);
      end
      add(4'd0, DEB_C + 4);
   endtask

   // Monitor: pops a prediction on every flag rise, checks held values otherwise
   always @(negedge clk) begin
      if (!rst_n) begin
         fq = 1'b0;
      end else begin
         if (bif.flag && !fq) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_flag", int'(bif.flag), 0);
            end else begin
               cur = exp_q.pop_front();
               chk("flag_edge", cyc, cur.edge_n);
               chk("flag_timeout", int'(bif.timeout), int'(cur.to));
               chk("flag_botao", int'(bif.botao), int'(cur.b));
            end
         end else if (bif.flag) begin
            chk("hold_timeout", int'(bif.timeout), int'(cur.to));
            chk("hold_botao", int'(bif.botao), int'(cur.b));
         end else begin
            chk("timeout_without_flag", int'(bif.timeout), 0);
         end
         fq = bif.flag;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running, want finished");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      bif.enable = 1'b0;
      bif.botoes = 4'd0;
      botao_m    = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flag", int'(bif.flag), 0);
      chk("reset_timeout", int'(bif.timeout), 0);
      chk("reset_botao", int'(bif.botao), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // clean press of button 2
      gq.delete(); add(4'd0, 3); add(4'b0100, 10); add(4'd0, 12);
      run_txn(0, 0); idle(2);

      // bouncing button 1, then a stable hold
      gq.delete(); add(4'd0, 3);
      for (int r = 0; r < 6; r++) begin add(4'b0010, 1); add(4'd0, 1); end
      add(4'b0010, 8); add(4'd0, 12);
      run_txn(0, 0); idle(2);

      // button held when enable rises, then a chord
      bif.botoes = 4'b0001; idle(3);
      gq.delete(); add(4'b0001, 17); add(4'd0, 2); add(4'b0011, 60);
      run_txn(0, 0);
      bif.botoes = 4'd0; idle(2);

      // no input at all
      gq.delete(); add(4'd0, 60);
      run_txn(0, 0); idle(2);

      // abort in the middle of a debounce, then capture button 3
      gq.delete(); add(4'd0, 3); add(4'b1000, 10); add(4'd0, 10);
      run_txn(7, 0); idle(2);
      gq.delete(); add(4'd0, 3); add(4'b1000, 6); add(4'd0, 10);
      run_txn(0, 0);

      // enable back on in the same cycle the flag drops
      gq.delete(); add(4'd0, 2); add(4'b0010, 7); add(4'd0, 10);
      run_txn(0, 0); idle(2);

      // reset while waiting for release, then capture button 3
      gq.delete(); add(4'd0, 3); add(4'b0001, 8); add(4'd0, 10);
      run_txn(0, 11); idle(2);
      gq.delete(); add(4'd0, 3); add(4'b1000, 6); add(4'd0, 10);
      run_txn(0, 0); idle(2);

      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            bif.botoes = 4'($urandom_range(0, 15));
            idle($urandom_range(1, 3));
         end else begin
            idle($urandom_range(0, 3));
         end
         rand_gq();
         run_txn(($urandom_range(0, 4) == 0) ? -1 : 0, 0);
      end

      idle(3);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
